isa_io_engine: RTL and testbench
================================

# isa_io_engine

Parametrised ISA I/O cycle engine between the HPS register interface and the CT2960 riser bus. It takes single read or write commands from the HPS over a valid/ready handshake and runs one complete ISA I/O cycle: address setup, IOR_n/IOW_n strobe, IOCHRDY wait-state extension with timeout, and hold. It then returns a response with read data and an error flag. It supersedes the static address/data latch with directly-driven strobes, giving programmable bus timing and back-pressure toward the HPS.

## Interface
Parameters:
- DATA_WIDTH, 16: ISA data width (8 or 16)
- ADDR_WIDTH, 16: I/O address width
- SETUP_CYCLES, 2: address/data valid before strobe, ≥1
- STROBE_CYCLES, 4: minimum strobe-low time, ≥1
- HOLD_CYCLES, 1: address/data held after strobe release, ≥1
- TIMEOUT_CYCLES, 16: maximum IOCHRDY extension cycles, ≥1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  HPS command present
- cmd_ready  out  1  engine accepts a command (IDLE only)
- cmd_write  in  1  1 = I/O write, 0 = I/O read
- cmd_addr  in  ADDR_WIDTH  I/O address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  HPS consumes response
- rsp_rdata  out  DATA_WIDTH  read data (write: all zeros)
- rsp_error  out  1  cycle ended by timeout
- address_bus  out  ADDR_WIDTH  ISA address
- data_bus_out  out  DATA_WIDTH  ISA write data
- data_bus_oe  out  1  drive enable for data_bus_out
- data_bus_in  in  DATA_WIDTH  ISA read data
- IOW_n  out  1  ISA write strobe, active-low
- IOR_n  out  1  ISA read strobe, active-low
- iochrdy  in  1  asynchronous ISA ready, low = extend

## Operation
- All outputs are registered. Reset values: cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, address_bus=0, data_bus_out=0, data_bus_oe=0, IOW_n=1, IOR_n=1.
- States: IDLE → SETUP → STROBE → HOLD → RESP → IDLE.
- IDLE: cmd_ready=1. When cmd_valid && cmd_ready, latch the command, load address_bus, and, for writes, load data_bus_out and set data_bus_oe=1. Go to SETUP.
- SETUP: SETUP_CYCLES cycles, strobes high. Go to STROBE.
- STROBE: the selected strobe (IOW_n or IOR_n) is low. After STROBE_CYCLES cycles, if synchronised iochrdy=0, stay and increment the extension counter. The counter reaching TIMEOUT_CYCLES forces exit with the error flag set.
- Read data is captured from data_bus_in on the edge that ends the final strobe cycle. On timeout, captured data is forced to all ones.
- HOLD: HOLD_CYCLES cycles, strobes high. Address and data are unchanged. data_bus_oe drops at HOLD exit.
- RESP: rsp_valid=1 and rsp_rdata/rsp_error are stable until rsp_ready. Exit on rsp_valid && rsp_ready, then return to IDLE. rsp_valid and rsp_error clear.
- address_bus and data_bus_out retain their last values in IDLE.
- IOR_n and IOW_n are never both low.
- cmd_* is ignored outside IDLE. rsp_ready is ignored outside RESP.
- Counter widths are $clog2(max parameter + 1). No wrap is possible.
- Reset mid-cycle: outputs go to reset values immediately (strobe released asynchronously). The FSM goes to IDLE and the pending response is discarded.

## Timing
- Command accepted in cycle 0.
- SETUP occupies cycles 1..SETUP_CYCLES.
- Strobe is low from cycle SETUP_CYCLES+1 for STROBE_CYCLES+E cycles, where E = number of extension cycles.
- HOLD follows the strobe.
- First rsp_valid cycle = SETUP_CYCLES+STROBE_CYCLES+E+HOLD_CYCLES+1.
- iochrdy passes through a 2-flop synchroniser. A low level must be present at least 2 cycles before the last nominal strobe cycle to guarantee extension.
- Back-to-back throughput: one command per SETUP+STROBE+HOLD+2 cycles (the extra two cycles are RESP and IDLE).

## Structure
- isa_bus_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RESP)
  - default timing constants
  - the all-ones timeout data constant
- Sub-module isa_rdy_sync: 2-flop synchroniser for iochrdy, asynchronous reset to 1 (ready).

## Test plan
All scenarios use defaults 2/4/1/16.
- Write 0x1234 to 0x0220, iochrdy=1 → IOW_n low cycles 3–6; data_bus_oe=1 cycles 1–7; rsp_valid at cycle 8 with rsp_error=0.
- Read 0x0388 with data_bus_in=0xBEEF, iochrdy=1 → IOR_n low cycles 3–6; rsp_rdata=0xBEEF at cycle 8.
- Read with iochrdy low for 5 cycles spanning the strobe end → strobe extended by the synchronised low count; data sampled after release; rsp_error=0.
- iochrdy held low → IOR_n low cycles 3–22; rsp_rdata=0xFFFF, rsp_error=1.
- rsp_ready held low 10 cycles with cmd_valid high → cmd_ready stays 0 and rsp fields stay stable. The next command is accepted only after the handshake.
- Assert reset during STROBE → IOW_n=1 and data_bus_oe=0 with no clock edge; after release, cmd_ready=1 and no rsp_valid.

Source files
------------

// File: rtl/isa_io_engine_pkg.sv
// Shared types and constants for the ISA I/O cycle engine.
// State encoding, default timing and timeout data pattern.
package isa_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_SETUP      = 2;
  localparam int DEF_STROBE     = 4;
  localparam int DEF_HOLD       = 1;
  localparam int DEF_TIMEOUT    = 16;

  localparam logic [63:0] TIMEOUT_DATA = '1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/isa_io_engine_if.sv
// HPS-side command/response handshake bundle.
// master = HPS, slave = cycle engine.
interface isa_io_engine_if
  import isa_bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/isa_io_engine_rdy_sync.sv
// Two-flop synchroniser for the asynchronous ISA IOCHRDY line.
// Resets to ready so a cycle never extends out of reset.
module isa_rdy_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/isa_io_engine.sv
// ISA I/O cycle engine: one HPS command -> one full ISA I/O cycle
// with setup, strobe, IOCHRDY extension/timeout, hold and response.
module isa_io_engine
  import isa_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int SETUP_CYCLES   = DEF_SETUP,
  parameter int STROBE_CYCLES  = DEF_STROBE,
  parameter int HOLD_CYCLES    = DEF_HOLD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  isa_io_engine_if.slave        hps,
  output logic [ADDR_WIDTH-1:0] address_bus,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic                  data_bus_oe,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic                  IOW_n,
  output logic                  IOR_n,
  input  logic                  iochrdy
);

  localparam int CW =
    $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);
  localparam int EW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [EW-1:0] EXT_MAX     = EW'(TIMEOUT_CYCLES);

  localparam logic [DATA_WIDTH-1:0] TO_DATA =
    TIMEOUT_DATA[DATA_WIDTH-1:0];

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [EW-1:0]         ext;
  logic                  is_wr;
  logic                  rdy_sync;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  assign hps.cmd_ready = cmd_ready_q;
  assign hps.rsp_valid = rsp_valid_q;
  assign hps.rsp_error = rsp_error_q;
  assign hps.rsp_rdata = rsp_rdata_q;

  isa_rdy_sync u_rdy_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (iochrdy),
    .sync_out (rdy_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ext          <= '0;
      is_wr        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      address_bus  <= '0;
      data_bus_out <= '0;
      data_bus_oe  <= 1'b0;
      IOW_n        <= 1'b1;
      IOR_n        <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hps.cmd_valid && cmd_ready_q) begin
            is_wr       <= hps.cmd_write;
            address_bus <= hps.cmd_addr;
            if (hps.cmd_write) begin
              data_bus_out <= hps.cmd_wdata;
              data_bus_oe  <= 1'b1;
            end
            cmd_ready_q <= 1'b0;
            cnt         <= '0;
            ext         <= '0;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            IOW_n <= ~is_wr;
            IOR_n <= is_wr;
            state <= ST_STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          // cnt parks on the last nominal cycle while IOCHRDY extends
          if (cnt != STROBE_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (rdy_sync || ext == EXT_MAX) begin
            IOW_n       <= 1'b1;
            IOR_n       <= 1'b1;
            cnt         <= '0;
            rsp_error_q <= ~rdy_sync;
            if (is_wr)
              rsp_rdata_q <= '0;
            else if (rdy_sync)
              rsp_rdata_q <= data_bus_in;
            else
              rsp_rdata_q <= TO_DATA;
            state <= ST_HOLD;
          end else begin
            ext <= ext + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt         <= '0;
            data_bus_oe <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_valid_q && hps.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isa_io_engine.sv
// Directed bench for isa_io_engine with default timing 2/4/1/16.
// Cycle n = n-th clock after the command is presented.
module tb_isa_io_engine;

  logic        clk;
  logic        reset;
  logic [15:0] address_bus;
  logic [15:0] data_bus_out;
  logic        data_bus_oe;
  logic [15:0] data_bus_in;
  logic        IOW_n;
  logic        IOR_n;
  logic        iochrdy;

  int n_cmp;
  int n_err;

  isa_io_engine_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) hps ();

  isa_io_engine dut (
    .clk          (clk),
    .reset        (reset),
    .hps          (hps),
    .address_bus  (address_bus),
    .data_bus_out (data_bus_out),
    .data_bus_oe  (data_bus_oe),
    .data_bus_in  (data_bus_in),
    .IOW_n        (IOW_n),
    .IOR_n        (IOR_n),
    .iochrdy      (iochrdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    iochrdy = 1'b1;
    data_bus_in = 16'h0000;
    hps.cmd_valid = 1'b0;
    hps.cmd_write = 1'b0;
    hps.cmd_addr  = 16'h0000;
    hps.cmd_wdata = 16'h0000;
    hps.rsp_ready = 1'b1;

    #12;
    chk("rst_cmd_ready", 32'(hps.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(hps.rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(hps.rsp_error), 32'd0);
    chk("rst_rsp_rdata", 32'(hps.rsp_rdata), 32'd0);
    chk("rst_addr", 32'(address_bus), 32'd0);
    chk("rst_dout", 32'(data_bus_out), 32'd0);
    chk("rst_oe", 32'(data_bus_oe), 32'd0);
    chk("rst_iow", 32'(IOW_n), 32'd1);
    chk("rst_ior", 32'(IOR_n), 32'd1);
    reset = 1'b0;
    tick();

    // write 0x1234 -> 0x0220
    hps.cmd_valid = 1'b1;
    hps.cmd_write = 1'b1;
    hps.cmd_addr  = 16'h0220;
    hps.cmd_wdata = 16'h1234;
    for (int c = 1; c <= 8; c++) begin
      tick();
      hps.cmd_valid = 1'b0;
      chk($sformatf("wr_iow_c%0d", c), 32'(IOW_n),
          (c >= 3 && c <= 6) ? 32'd0 : 32'd1);
      chk($sformatf("wr_ior_c%0d", c), 32'(IOR_n), 32'd1);
      chk($sformatf("wr_oe_c%0d", c), 32'(data_bus_oe),
          (c >= 1 && c <= 7) ? 32'd1 : 32'd0);
      chk($sformatf("wr_rv_c%0d", c), 32'(hps.rsp_valid),
          (c == 8) ? 32'd1 : 32'd0);
    end
    chk("wr_err", 32'(hps.rsp_error), 32'd0);
    chk("wr_rdata", 32'(hps.rsp_rdata), 32'd0);
    chk("wr_addr", 32'(address_bus), 32'h0220);
    chk("wr_dout", 32'(data_bus_out), 32'h1234);
    tick();
    chk("wr_idle_ready", 32'(hps.cmd_ready), 32'd1);
    chk("wr_idle_rv", 32'(hps.rsp_valid), 32'd0);
    chk("wr_idle_addr", 32'(address_bus), 32'h0220);
    chk("wr_idle_dout", 32'(data_bus_out), 32'h1234);

    // read 0x0388, bus returns 0xBEEF
    data_bus_in = 16'hBEEF;
    hps.cmd_valid = 1'b1;
    hps.cmd_write = 1'b0;
    hps.cmd_addr  = 16'h0388;
    for (int c = 1; c <= 8; c++) begin
      tick();
      hps.cmd_valid = 1'b0;
      chk($sformatf("rd_ior_c%0d", c), 32'(IOR_n),
          (c >= 3 && c <= 6) ? 32'd0 : 32'd1);
      chk($sformatf("rd_iow_c%0d", c), 32'(IOW_n), 32'd1);
      chk($sformatf("rd_oe_c%0d", c), 32'(data_bus_oe), 32'd0);
      chk($sformatf("rd_rv_c%0d", c), 32'(hps.rsp_valid),
          (c == 8) ? 32'd1 : 32'd0);
    end
    chk("rd_rdata", 32'(hps.rsp_rdata), 32'hBEEF);
    chk("rd_err", 32'(hps.rsp_error), 32'd0);
    chk("rd_addr", 32'(address_bus), 32'h0388);
    tick();

    // iochrdy low cycles 4..8 -> synced low 6..10, strobe 3..11
    data_bus_in = 16'h1111;
    hps.cmd_valid = 1'b1;
    hps.cmd_addr  = 16'h0390;
    for (int c = 1; c <= 13; c++) begin
      tick();
      hps.cmd_valid = 1'b0;
      iochrdy = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
      if (c >= 9) data_bus_in = 16'h5A5A;
      chk($sformatf("ext_ior_c%0d", c), 32'(IOR_n),
          (c >= 3 && c <= 11) ? 32'd0 : 32'd1);
      chk($sformatf("ext_rv_c%0d", c), 32'(hps.rsp_valid),
          (c == 13) ? 32'd1 : 32'd0);
    end
    chk("ext_rdata", 32'(hps.rsp_rdata), 32'h5A5A);
    chk("ext_err", 32'(hps.rsp_error), 32'd0);
    tick();

    // iochrdy stuck low -> timeout after 16 extension cycles
    hps.cmd_valid = 1'b1;
    hps.cmd_addr  = 16'h0398;
    for (int c = 1; c <= 24; c++) begin
      tick();
      hps.cmd_valid = 1'b0;
      iochrdy = 1'b0;
      chk($sformatf("to_ior_c%0d", c), 32'(IOR_n),
          (c >= 3 && c <= 22) ? 32'd0 : 32'd1);
      chk($sformatf("to_rv_c%0d", c), 32'(hps.rsp_valid),
          (c == 24) ? 32'd1 : 32'd0);
    end
    chk("to_rdata", 32'(hps.rsp_rdata), 32'hFFFF);
    chk("to_err", 32'(hps.rsp_error), 32'd1);
    iochrdy = 1'b1;
    tick();
    chk("to_clear_err", 32'(hps.rsp_error), 32'd0);
    chk("to_clear_rv", 32'(hps.rsp_valid), 32'd0);

    // response back-pressure with a new command waiting
    hps.rsp_ready = 1'b0;
    data_bus_in = 16'h0042;
    hps.cmd_valid = 1'b1;
    hps.cmd_write = 1'b0;
    hps.cmd_addr  = 16'h0300;
    for (int c = 1; c <= 8; c++) begin
      tick();
      hps.cmd_valid = 1'b0;
    end
    chk("bp_rv_c8", 32'(hps.rsp_valid), 32'd1);
    hps.cmd_valid = 1'b1;
    hps.cmd_write = 1'b1;
    hps.cmd_addr  = 16'h0310;
    hps.cmd_wdata = 16'h9999;
    data_bus_in = 16'h7777;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_cr_%0d", i), 32'(hps.cmd_ready), 32'd0);
      chk($sformatf("bp_rv_%0d", i), 32'(hps.rsp_valid), 32'd1);
      chk($sformatf("bp_rd_%0d", i), 32'(hps.rsp_rdata), 32'h0042);
      chk($sformatf("bp_er_%0d", i), 32'(hps.rsp_error), 32'd0);
      chk($sformatf("bp_ad_%0d", i), 32'(address_bus), 32'h0300);
    end
    hps.rsp_ready = 1'b1;
    tick();
    chk("bp_hs_rv", 32'(hps.rsp_valid), 32'd0);
    chk("bp_hs_cr", 32'(hps.cmd_ready), 32'd1);
    tick();
    hps.cmd_valid = 1'b0;
    chk("bp_next_cr", 32'(hps.cmd_ready), 32'd0);
    chk("bp_next_addr", 32'(address_bus), 32'h0310);
    chk("bp_next_dout", 32'(data_bus_out), 32'h9999);
    chk("bp_next_oe", 32'(data_bus_oe), 32'd1);

    // asynchronous reset in the middle of the write strobe (cycle 4)
    tick();
    tick();
    tick();
    chk("rs_iow_low", 32'(IOW_n), 32'd0);
    chk("rs_oe_high", 32'(data_bus_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_iow", 32'(IOW_n), 32'd1);
    chk("rs_oe", 32'(data_bus_oe), 32'd0);
    chk("rs_cr", 32'(hps.cmd_ready), 32'd1);
    chk("rs_addr", 32'(address_bus), 32'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rs_post_cr_%0d", i), 32'(hps.cmd_ready), 32'd1);
      chk($sformatf("rs_post_rv_%0d", i), 32'(hps.rsp_valid), 32'd0);
      chk($sformatf("rs_post_iow_%0d", i), 32'(IOW_n), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
